// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_n
// Description : Digit-serial adder/subtractor, DIGIT bits per clock with a
//               registered carry; start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_n     = WIDTH / DIGIT;
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder_n: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [DIGIT:0]       w_digit;
  logic [WIDTH-1:0]     w_sum_next;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == c_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_digit = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

  // Result digits enter at the MSB end so the first digit lands at bit 0.
  generate
    if (WIDTH == DIGIT) begin : g_sum_single
      assign w_sum_next = w_digit[DIGIT-1:0];
    end else begin : g_sum_shift
      assign w_sum_next = {w_digit[DIGIT-1:0], r_sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1; cin is ignored in that mode.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= w_sum_next;
      r_carry <= w_digit[DIGIT];
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  assign sum  = r_sum;
  assign cout = r_carry;

endmodule
`default_nettype wire
